// File: rtl/axi_regfile_pkg.sv
// axi_regfile_pkg: shared constants and sizing helper for the AXI4-Lite register file
package axi_regfile_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int DATA_W = 32;
  function automatic int nregs(input int addr_w);
    return 2 ** (addr_w - 2);
  endfunction
endpackage

// File: rtl/axi_regfile.sv
// axi_regfile: AXI4-Lite slave; writes land in slv_reg, reads return fabric-supplied slv_read
module axi_regfile
  import axi_regfile_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                                                   S_AXI_ACLK,
  input  logic                                                   S_AXI_ARESET,
  output logic [nregs(C_S_AXI_ADDR_WIDTH)-1:0][DATA_W-1:0]       slv_reg,
  input  logic [nregs(C_S_AXI_ADDR_WIDTH)-1:0][DATA_W-1:0]       slv_read,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          S_AXI_AWADDR,
  input  logic [2:0]                                             S_AXI_AWPROT,
  input  logic                                                   S_AXI_AWVALID,
  output logic                                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                        S_AXI_WSTRB,
  input  logic                                                   S_AXI_WVALID,
  output logic                                                   S_AXI_WREADY,
  output logic [1:0]                                             S_AXI_BRESP,
  output logic                                                   S_AXI_BVALID,
  input  logic                                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          S_AXI_ARADDR,
  input  logic [2:0]                                             S_AXI_ARPROT,
  input  logic                                                   S_AXI_ARVALID,
  output logic                                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                          S_AXI_RDATA,
  output logic [1:0]                                             S_AXI_RRESP,
  output logic                                                   S_AXI_RVALID,
  input  logic                                                   S_AXI_RREADY
);
  logic aw_go, ar_go, wr_en, rd_en, unused;
  logic [C_S_AXI_ADDR_WIDTH-3:0] widx, ridx;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign widx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  // ready is only offered once both address and data are present, and never while a response is pending
  assign aw_go = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
  assign wr_en = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WREADY && S_AXI_WVALID;
  assign ar_go = S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
  assign rd_en = S_AXI_ARREADY && S_AXI_ARVALID;
  assign S_AXI_BRESP = AXI_RESP_OKAY;
  assign S_AXI_RRESP = AXI_RESP_OKAY;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      slv_reg       <= '0;
    end else begin
      S_AXI_AWREADY <= aw_go;
      S_AXI_WREADY  <= aw_go;
      S_AXI_BVALID  <= wr_en ? 1'b1 : (S_AXI_BREADY ? 1'b0 : S_AXI_BVALID);
      if (wr_en)
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
          if (S_AXI_WSTRB[b]) slv_reg[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end
  // read data is sampled at the address handshake edge, so a same-cycle write is not yet visible
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= ar_go;
      S_AXI_RVALID  <= rd_en ? 1'b1 : (S_AXI_RREADY ? 1'b0 : S_AXI_RVALID);
      if (rd_en) S_AXI_RDATA <= slv_read[ridx];
    end
  end
endmodule

// File: tb/tb_axi_regfile.sv
// tb_axi_regfile: directed self-checking bench for axi_regfile
module tb_axi_regfile;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0][31:0] slv_reg, slv_read, ext_read;
  logic loop = 1'b1;
  logic [6:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata, held;
  logic [3:0] wstrb = '0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0] bresp, rresp;
  int tests = 0, failed = 0;
  assign slv_read = loop ? slv_reg : ext_read;
  always #5 clk = ~clk;
  axi_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .slv_reg(slv_reg), .slv_read(slv_read),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_aw();
    for (int n = 0; n < 20 && !awready; n++) step();
    chk("awready", {31'd0, awready}, 32'd1);
    chk("wready", {31'd0, wready}, 32'd1);
  endtask
  task automatic wait_ar();
    for (int n = 0; n < 20 && !arready; n++) step();
    chk("arready", {31'd0, arready}, 32'd1);
  endtask
  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    wait_aw();
    step();
    awvalid = 0; wvalid = 0;
    chk("bvalid", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    step();
    chk("bvalid_clr", {31'd0, bvalid}, 32'd0);
  endtask
  task automatic axi_read(input logic [6:0] a, input logic [31:0] exp, input string tag);
    araddr = a; arvalid = 1; rready = 1;
    wait_ar();
    step();
    arvalid = 0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
    chk("rresp", {30'd0, rresp}, 32'd0);
    step();
    chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
  endtask
  initial begin
    ext_read = '0;
    #1 rst = 1;
    #1;
    chk("rst_reg0", slv_reg[0], 32'd0);
    chk("rst_ready", {28'd0, awready, wready, arready, bvalid}, 32'd0);
    chk("rst_rvalid_rdata", rdata | {31'd0, rvalid}, 32'd0);
    step();
    rst = 0;
    step();
    for (int i = 0; i < 32; i++) axi_write(7'(4 * i), 32'hAA000000 + 32'(i), 4'hF);
    for (int i = 0; i < 32; i++) axi_read(7'(4 * i), 32'hAA000000 + 32'(i), "loop_rdata");
    axi_write(7'h0C, 32'hFFFFFFFF, 4'hF);
    axi_write(7'h0D, 32'h12345678, 4'b0101);
    chk("strb_reg3", slv_reg[3], 32'hFF34FF78);
    axi_read(7'h0E, 32'hFF34FF78, "strb_read");
    awaddr = 7'd40; wdata = 32'h00001010; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    wait_aw();
    step();
    awaddr = 7'd44; wdata = 32'h00001111;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_awready", {31'd0, awready}, 32'd0);
      step();
    end
    chk("bp_first_landed", slv_reg[10], 32'h00001010);
    chk("bp_second_held", slv_reg[11], 32'hAA00000B);
    bready = 1;
    step();
    chk("bp_bvalid_clr", {31'd0, bvalid}, 32'd0);
    wait_aw();
    step();
    awvalid = 0; wvalid = 0;
    chk("bp_bvalid2", {31'd0, bvalid}, 32'd1);
    chk("bp_second_landed", slv_reg[11], 32'h00001111);
    step();
    araddr = 7'd40; arvalid = 1; rready = 0;
    wait_ar();
    step();
    arvalid = 0; loop = 0; ext_read = {32{32'h5A5A5A5A}};
    held = rdata;
    chk("rbp_first", held, 32'h00001010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rbp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("rbp_rdata", rdata, 32'h00001010);
    end
    rready = 1;
    step();
    chk("rbp_rvalid_clr", {31'd0, rvalid}, 32'd0);
    loop = 1;
    awaddr = 7'd80; wdata = 32'hC0FFEE20; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("skew_ready", {30'd0, awready, wready}, 32'd0);
    end
    wvalid = 1;
    wait_aw();
    step();
    awvalid = 0; wvalid = 0;
    chk("skew_reg20", slv_reg[20], 32'hC0FFEE20);
    chk("skew_reg21", slv_reg[21], 32'hAA000015);
    step();
    loop = 0; ext_read = '0; ext_read[5] = 32'hDEADBEEF;
    axi_read(7'h14, 32'hDEADBEEF, "ext_0x14");
    axi_read(7'h17, 32'hDEADBEEF, "ext_0x17");
    axi_read(7'h18, 32'h00000000, "ext_0x18");
    loop = 1;
    awaddr = 7'h1C; wdata = 32'h00000011; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    araddr = 7'h1C; arvalid = 1; rready = 0;
    wait_aw();
    chk("same_cycle_arready", {31'd0, arready}, 32'd1);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_cycle_old", rdata, 32'hAA000007);
    chk("rst_pre_reg7", slv_reg[7], 32'h00000011);
    chk("rst_pre_valids", {30'd0, bvalid, rvalid}, 32'd3);
    #2 rst = 1;
    #1;
    chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_reg7", slv_reg[7], 32'd0);
    chk("rst_reg20", slv_reg[20], 32'd0);
    step();
    rst = 0;
    step();
    axi_write(7'h1C, 32'h00000022, 4'hF);
    chk("post_rst_reg7", slv_reg[7], 32'h00000022);
    axi_read(7'h1C, 32'h00000022, "post_rst_read");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/axi_regfile.md
Name: axi_regfile

Overview:
- AXI4-Lite slave register file with NREGS = 2**(C_S_AXI_ADDR_WIDTH-2) 32-bit registers.
- Write transactions update the internal registers, which drive the slv_reg output array to fabric logic.
- Read transactions return the fabric-supplied slv_read array, so a register may be read back directly (slv_read tied to slv_reg) or may expose status.
- Sits between the PS/interconnect AXI-Lite master port and PL control/status logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte-address width. Word index = addr[C_S_AXI_ADDR_WIDTH-1:2]. NREGS = 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- slv_reg  out  [NREGS-1:0][31:0]  register contents, written via AXI.
- slv_read  in  [NREGS-1:0][31:0]  values returned on AXI reads.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 ;  S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 ;  S_AXI_WSTRB  in  4 ;  S_AXI_WVALID  in  1 ;  S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 ;  S_AXI_BVALID  out  1 ;  S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH ;  S_AXI_ARPROT  in  3 (ignored) ;  S_AXI_ARVALID  in  1 ;  S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 ;  S_AXI_RRESP  out  2 ;  S_AXI_RVALID  out  1 ;  S_AXI_RREADY  in  1

Behaviour:
- Reset (asynchronous, while S_AXI_ARESET=1):
  - all slv_reg = 0;
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0;
  - RDATA = 0; BRESP = RRESP = 2'b00.
  - An in-flight transaction is abandoned with no response.
- Write channel:
  - AWREADY and WREADY pulse high together for exactly one cycle in the cycle after AWVALID && WVALID && !AWREADY && !BVALID.
  - The address is captured at that edge.
  - At the handshake edge, for each byte b with WSTRB[b]=1: slv_reg[idx][8b+7:8b] <= WDATA[8b+7:8b]. Bytes with a strobe of 0 are unchanged.
  - BVALID rises on the next edge with BRESP=OKAY. It holds until BREADY; no new write is accepted while BVALID=1.
  - AWVALID without WVALID, or the reverse, is held off: no ready is asserted until both are valid.
  - Write latency: 1 cycle to ready, 1 more cycle to BVALID, so a minimum of 3 cycles per write.
- Read channel:
  - ARREADY pulses high for one cycle in the cycle after ARVALID && !ARREADY && !RVALID. The address is latched.
  - On the next edge: RVALID=1, RDATA = slv_read[idx] sampled at that edge, RRESP=OKAY.
  - RDATA and RVALID are held stable until RREADY; RVALID clears on the RREADY edge.
  - Minimum 3 cycles per read.
- Address decode:
  - addr[1:0] is ignored.
  - Bits at or above C_S_AXI_ADDR_WIDTH are not present, so upper master address bits alias.
  - All indices are valid; there are no error responses.
- Read and write channels are independent and may complete in the same cycle.
  - When a write and a read hit the same index in the same cycle, the read returns slv_read as sampled that cycle, i.e. old data in loopback.
- slv_reg changes only on write handshake edges.

Decomposition:
- Package axi_regfile_pkg:
  - localparams AXI_RESP_OKAY = 2'b00 and DATA_W = 32;
  - function nregs(addr_w).
- No sub-module required. The write and read channel FSMs are two always_ff blocks in one module.

Test Plan:
- Loopback (slv_read=slv_reg), ADDR_WIDTH=7: write AA000000+i to address 4*i for i=0..31, then read all 32 back → each RDATA = AA000000+i, RRESP=0, BRESP=0 on every write.
- Byte strobes: write FFFFFFFF to reg 3, then write 12345678 with WSTRB=4'b0101 → slv_reg[3] = FF34FF78.
- Backpressure:
  - hold BREADY=0 for 5 cycles after a write → BVALID stays 1, AWREADY stays 0 for a second pending write; releasing BREADY completes both in order.
  - hold RREADY=0 → RDATA stays stable.
- Channel skew: AWVALID asserted 4 cycles before WVALID → AWREADY/WREADY stay 0 until both are valid, then pulse together; the data lands in the correct register.
- Non-loopback read: drive slv_read[5]=DEADBEEF, read address 0x14 (and 0x17) → RDATA = DEADBEEF.
- Reset mid-transaction: assert S_AXI_ARESET while BVALID=1 and after writing 0x11 to reg 7 → BVALID and RVALID drop immediately, slv_reg[7] = 0, and the next write/read after deassertion works normally.
